// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period and high time in clk cycles
// Ports: clk, nrst (async active-low); en = capture enable; pwm_in = async PWM pin;
// period_cnt/high_cnt = last complete period and its high time; valid = 1-cycle
// strobe on a new result pair; timeout = level, no edge within 2**WIDTH-1 cycles.
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_cnt,
  output logic [WIDTH-1:0] high_cnt,
  output logic             valid,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, SEEK, HIGH, LOW} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d, hi_lat_q, hi_lat_d, per_q, per_d, high_q, high_d;
  logic                   valid_q, valid_d, timeout_q, timeout_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise, fall, sat;
  assign rise       = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall       = ~sync_q[SYNC_STAGES-1] & dly_q;
  assign sat        = cnt_q == MAX;
  assign period_cnt = per_q;
  assign high_cnt   = high_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      per_q     <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      sync_q    <= '0;
      dly_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      per_q     <= per_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      dly_q     <= sync_q[SYNC_STAGES-1];
    end
  end
  // An edge on the saturating cycle takes priority over the timeout path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    per_d     = per_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = SEEK;
        end
        SEEK: begin
          cnt_d   = rise ? WIDTH'(1) : cnt_q;
          state_d = rise ? HIGH : SEEK;
        end
        HIGH: begin
          if (fall) begin
            hi_lat_d = cnt_q;
            cnt_d    = cnt_q + 1'b1;
            state_d  = LOW;
          end else if (sat) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = SEEK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            per_d     = cnt_q;
            high_d    = hi_lat_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = WIDTH'(1);
            state_d   = HIGH;
          end else if (sat) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = SEEK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture
module tb_pwm_capture;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] period_cnt, high_cnt;
  logic        valid, timeout;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          q_p[$];
  int          q_h[$];
  int          last_p = 0;
  int          last_h = 0;
  bit          armed = 1'b0;
  int          prev_p = 0;
  int          prev_h = 0;
  pwm_capture dut (
    .clk(clk), .nrst(nrst), .en(en), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .valid(valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (nrst && valid) begin
      if (q_p.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        last_p = q_p.pop_front();
        last_h = q_h.pop_front();
        check("period", {16'd0, period_cnt}, last_p);
        check("high", {16'd0, high_cnt}, last_h);
        check("timeout_on_valid", {31'd0, timeout}, 0);
      end
    end
  end
  task automatic rise_mark(input int p, input int h);
    if (armed) begin
      q_p.push_back(prev_p);
      q_h.push_back(prev_h);
    end
    armed  = 1'b1;
    prev_p = p;
    prev_h = h;
  endtask
  task automatic pulse(input int p, input int h);
    rise_mark(p, h);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask
  task automatic idle(input int n);
    if (armed) prev_p += n;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #2;
    check("rst_period", {16'd0, period_cnt}, 0);
    check("rst_high", {16'd0, high_cnt}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_timeout", {31'd0, timeout}, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    en   = 1'b1;
    idle(5);
    repeat (4) pulse(1000, 300);
    check("no_timeout", {31'd0, timeout}, 0);
    repeat (3) pulse(1000, 750);
    repeat (2) pulse(1000, 300);
    pulse(66050, 66000);
    armed = 1'b0;
    check("timeout_set", {31'd0, timeout}, 1);
    check("timeout_held_p", {16'd0, period_cnt}, last_p);
    pulse(1000, 300);
    check("timeout_still", {31'd0, timeout}, 1);
    repeat (3) pulse(1000, 300);
    check("timeout_cleared", {31'd0, timeout}, 0);
    repeat (6) pulse(4, 1);
    repeat (2) pulse(1000, 300);
    rise_mark(1000, 300);
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    en    = 1'b0;
    armed = 1'b0;
    repeat (50) @(negedge clk);
    check("dis_hold_p", {16'd0, period_cnt}, last_p);
    check("dis_hold_h", {16'd0, high_cnt}, last_h);
    check("dis_hold_to", {31'd0, timeout}, 0);
    en = 1'b1;
    repeat (200) @(negedge clk);
    pwm_in = 1'b0;
    repeat (700) @(negedge clk);
    pulse(1000, 300);
    check("reen_hold_p", {16'd0, period_cnt}, last_p);
    repeat (3) pulse(1000, 400);
    rise_mark(1000, 300);
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("arst_period", {16'd0, period_cnt}, 0);
    check("arst_high", {16'd0, high_cnt}, 0);
    check("arst_valid", {31'd0, valid}, 0);
    check("arst_timeout", {31'd0, timeout}, 0);
    en     = 1'b0;
    armed  = 1'b0;
    last_p = 0;
    last_h = 0;
    repeat (5) @(negedge clk);
    nrst = 1'b1;
    repeat (2) begin
      pwm_in = 1'b1;
      repeat (300) @(negedge clk);
      pwm_in = 1'b0;
      repeat (700) @(negedge clk);
    end
    check("post_rst_p", {16'd0, period_cnt}, 0);
    check("post_rst_h", {16'd0, high_cnt}, 0);
    en = 1'b1;
    idle(5);
    repeat (3) pulse(500, 125);
    idle(20);
    check("sb_empty", q_p.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
